// File: rtl/serial_bus_pkg.sv
// Shared definitions for the single-wire serial bus: target FSM states and
// the encodings of the bus mode and direction lines.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RD_REQ,
    SPLIT,
    RD_SEND
  } tgt_state_e;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register with parallel load and a word-length bit counter.
// New bits enter at the MSB, so after WIDTH shifts the first bit sits at bit 0.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] count;

  assign data_next = {shift_in, data[WIDTH-1:1]};
  // done flags that the shift happening this cycle completes the word
  assign done      = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift_en) begin
      data  <= data_next;
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/target_port.sv
// Target endpoint of the single-wire serial bus: deserialises address and
// write data for the local core, and serialises read data back with split support.
module target_port
  import serial_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire                   bus_data,
  input  logic                  bus_data_in_valid,
  input  logic                  bus_mode,
  input  logic                  bus_init_rw,
  input  logic                  bus_init_ready,
  input  logic                  target_select,
  output logic                  bus_data_out_valid,
  output logic                  target_ack,
  output logic                  target_split,
  output logic [ADDR_WIDTH-1:0] tgt_addr,
  output logic                  tgt_addr_valid,
  output logic                  tgt_rw,
  output logic [DATA_WIDTH-1:0] tgt_wdata,
  output logic                  tgt_wdata_valid,
  input  logic [DATA_WIDTH-1:0] tgt_rdata,
  input  logic                  tgt_rdata_valid
);

  localparam int WAIT_W = $clog2(SPLIT_LATENCY + 1);

  tgt_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_sr_unused, addr_word;
  logic                  addr_shift, addr_done, addr_abort, addr_last;
  logic [DATA_WIDTH-1:0] data_sr, data_word;
  logic                  data_shift, data_done, data_in_bit, wdata_last;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  data_held, in_read_wait, rd_latch, timeout, launch;

  assign in_read_wait = (state == RD_REQ) || (state == SPLIT);
  assign addr_shift   = bus_data_in_valid && (bus_mode == MODE_ADDR) &&
                        (((state == IDLE) && target_select) || (state == ADDR));
  assign addr_abort   = (state == ADDR) && bus_data_in_valid && (bus_mode == MODE_DATA);
  assign addr_last    = (state == ADDR) && addr_shift && addr_done;
  assign data_shift   = ((state == WDATA) && bus_data_in_valid && (bus_mode == MODE_DATA)) ||
                        (state == RD_SEND);
  assign wdata_last   = (state == WDATA) && data_shift && data_done;
  assign data_in_bit  = (state == RD_SEND) ? 1'b0 : bus_data;

  // Read data is taken once; a late bus_init_ready leaves it parked in the shifter.
  assign rd_latch = in_read_wait && !data_held && tgt_rdata_valid;
  assign timeout  = (state == RD_REQ) && !data_held && !tgt_rdata_valid &&
                    (wait_cnt == WAIT_W'(SPLIT_LATENCY - 1));
  assign launch   = in_read_wait && (data_held || tgt_rdata_valid) && bus_init_ready;

  assign bus_data_out_valid = (state == RD_SEND);
  assign bus_data           = bus_data_out_valid ? data_sr[0] : 1'bz;

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (addr_abort),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (addr_shift),
    .shift_in  (bus_data),
    .data      (addr_sr_unused),
    .data_next (addr_word),
    .done      (addr_done)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state == IDLE),
    .load      (rd_latch),
    .load_data (tgt_rdata),
    .shift_en  (data_shift),
    .shift_in  (data_in_bit),
    .data      (data_sr),
    .data_next (data_word),
    .done      (data_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (addr_shift) state_nxt = ADDR;
      ADDR: begin
        if (addr_abort)     state_nxt = IDLE;
        else if (addr_last) state_nxt = (bus_init_rw == RW_WRITE) ? WDATA : RD_REQ;
      end
      WDATA:   if (wdata_last) state_nxt = IDLE;
      RD_REQ: begin
        if (launch)       state_nxt = RD_SEND;
        else if (timeout) state_nxt = SPLIT;
      end
      SPLIT:   if (launch) state_nxt = RD_SEND;
      RD_SEND: if (data_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered pulses appear the cycle after the edge that completes a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_addr        <= '0;
      tgt_addr_valid  <= 1'b0;
      tgt_rw          <= 1'b0;
      tgt_wdata       <= '0;
      tgt_wdata_valid <= 1'b0;
      target_ack      <= 1'b0;
      target_split    <= 1'b0;
      wait_cnt        <= '0;
      data_held       <= 1'b0;
    end else begin
      tgt_addr_valid  <= 1'b0;
      tgt_wdata_valid <= 1'b0;
      target_ack      <= 1'b0;
      if (addr_last) begin
        tgt_addr       <= addr_word;
        tgt_addr_valid <= 1'b1;
        tgt_rw         <= bus_init_rw;
      end
      if (wdata_last) begin
        tgt_wdata       <= data_word;
        tgt_wdata_valid <= 1'b1;
        target_ack      <= 1'b1;
      end
      if ((state == RD_SEND) && data_done) target_ack <= 1'b1;
      if (state == ADDR)                        wait_cnt <= '0;
      else if ((state == RD_REQ) && !data_held) wait_cnt <= wait_cnt + 1'b1;
      if (timeout)       target_split <= 1'b1;
      else if (rd_latch) target_split <= 1'b0;
      if (launch)        data_held <= 1'b0;
      else if (rd_latch) data_held <= 1'b1;
    end
  end

endmodule

// File: tb/tb_target_port.sv
// Randomised self-checking bench for target_port against a transaction-level model.
module tb_target_port;
  import serial_bus_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  wire           bus_data;
  logic          drv_bit;
  logic          bus_data_in_valid, bus_mode, bus_init_rw, bus_init_ready, target_select;
  logic          bus_data_out_valid, target_ack, target_split;
  logic [AW-1:0] tgt_addr;
  logic          tgt_addr_valid, tgt_rw;
  logic [DW-1:0] tgt_wdata;
  logic          tgt_wdata_valid;
  logic [DW-1:0] tgt_rdata;
  logic          tgt_rdata_valid;

  int n_checks = 0, n_fail = 0;
  int n_addr_pulse = 0, n_wdata_pulse = 0, n_ack_pulse = 0, n_ovld = 0;
  int exp_addr = 0, exp_wdata = 0, exp_ack = 0, exp_ovld = 0;

  assign bus_data = bus_data_in_valid ? drv_bit : 1'bz;

  always #5 clk = ~clk;

  target_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_LATENCY(LAT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_data           (bus_data),
    .bus_data_in_valid  (bus_data_in_valid),
    .bus_mode           (bus_mode),
    .bus_init_rw        (bus_init_rw),
    .bus_init_ready     (bus_init_ready),
    .target_select      (target_select),
    .bus_data_out_valid (bus_data_out_valid),
    .target_ack         (target_ack),
    .target_split       (target_split),
    .tgt_addr           (tgt_addr),
    .tgt_addr_valid     (tgt_addr_valid),
    .tgt_rw             (tgt_rw),
    .tgt_wdata          (tgt_wdata),
    .tgt_wdata_valid    (tgt_wdata_valid),
    .tgt_rdata          (tgt_rdata),
    .tgt_rdata_valid    (tgt_rdata_valid)
  );

  // Pulse and drive-cycle tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (tgt_addr_valid)     n_addr_pulse  <= n_addr_pulse + 1;
    if (tgt_wdata_valid)    n_wdata_pulse <= n_wdata_pulse + 1;
    if (target_ack)         n_ack_pulse   <= n_ack_pulse + 1;
    if (bus_data_out_valid) n_ovld        <= n_ovld + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input logic mode, input logic rw,
                           input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus_data_in_valid = 1'b0;
        repeat (gap_len) step();
      end
      bus_data_in_valid = 1'b1;
      drv_bit           = v[i];
      bus_mode          = mode;
      bus_init_rw       = rw;
      step();
    end
    bus_data_in_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int gap_a, input int gap_d);
    target_select = 1'b1;
    send_bits(32'(a), AW, MODE_ADDR, RW_WRITE, gap_a, 3);
    exp_addr++;
    check("wr_addr_vld", tgt_addr_valid, 1);
    check("wr_addr", tgt_addr, a);
    check("wr_rw", tgt_rw, 1);
    send_bits(32'(d), DW, MODE_DATA, RW_WRITE, gap_d, 3);
    exp_wdata++;
    exp_ack++;
    check("wr_data_vld", tgt_wdata_valid, 1);
    check("wr_ack", target_ack, 1);
    check("wr_data", tgt_wdata, d);
    check("wr_ovld", bus_data_out_valid, 0);
    target_select = 1'b0;
    step();
    check("wr_ack_once", target_ack, 0);
    check("wr_addr_hold", tgt_addr, a);
  endtask

  // Core answers 'delay' cycles after the request; initiator ready from cycle rdy_at.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay,
                         input int rdy_at, input int rst_after);
    int first, exp_first, split_hi, split_exp, split_first;
    logic [DW-1:0] got;
    bus_init_ready = 1'b0;
    target_select  = 1'b1;
    send_bits(32'(a), AW, MODE_ADDR, RW_READ, -1, 0);
    target_select  = 1'b0;
    exp_addr++;
    check("rd_addr_vld", tgt_addr_valid, 1);
    check("rd_addr", tgt_addr, a);
    check("rd_rw", tgt_rw, 0);
    exp_first   = ((delay > rdy_at) ? delay : rdy_at) + 1;
    first       = -1;
    split_hi    = 0;
    split_exp   = 0;
    split_first = -1;
    for (int cyc = 0; cyc < exp_first + 4 && first < 0; cyc++) begin
      tgt_rdata_valid = (cyc == delay);
      tgt_rdata       = (cyc == delay) ? d : DW'($urandom);
      bus_init_ready  = (cyc >= rdy_at);
      if (target_split) begin
        split_hi++;
        if (split_first < 0) split_first = cyc;
      end
      if (cyc >= LAT && cyc <= delay) split_exp++;
      if (bus_data_out_valid) first = cyc;
      else step();
    end
    tgt_rdata_valid = 1'b0;
    check("rd_first", first, exp_first);
    check("rd_split_cycles", split_hi, split_exp);
    check("rd_split_rise", split_first, (delay >= LAT) ? LAT : -1);
    if (first < 0) return;
    got = '0;
    for (int i = 0; i < DW; i++) begin
      if (i == rst_after) begin
        rst_n = 1'b0;
        #1;
        check("rst_ovld", bus_data_out_valid, 0);
        check("rst_ack", target_ack, 0);
        check("rst_addr", tgt_addr, 0);
        check("rst_rw", tgt_rw, 0);
        exp_ovld += rst_after;
        step();
        rst_n = 1'b1;
        bus_init_ready = 1'b0;
        step();
        return;
      end
      check("rd_ovld", bus_data_out_valid, 1);
      check("rd_split_low", target_split, 0);
      got[i] = bus_data;
      if (i > 0) bus_init_ready = 1'($urandom);
      step();
    end
    exp_ovld += DW;
    exp_ack++;
    check("rd_data", got, d);
    check("rd_release", bus_data_out_valid, 0);
    check("rd_ack", target_ack, 1);
    bus_init_ready = 1'b0;
    step();
    check("rd_ack_once", target_ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdv;
    int dly, rdy, ga, gd;
    rst_n = 1'b0;
    drv_bit = 1'b0;
    bus_data_in_valid = 1'b0;
    bus_mode = MODE_ADDR;
    bus_init_rw = RW_READ;
    bus_init_ready = 1'b0;
    target_select = 1'b0;
    tgt_rdata = '0;
    tgt_rdata_valid = 1'b0;
    repeat (3) step();
    check("rst_addr_vld", tgt_addr_valid, 0);
    check("rst_wdata_vld", tgt_wdata_valid, 0);
    check("rst_split", target_split, 0);
    check("rst_ovld0", bus_data_out_valid, 0);
    check("rst_wdata", tgt_wdata, 0);
    rst_n = 1'b1;
    step();

    do_write(16'hA55A, 8'h3C, -1, -1);
    do_read(16'h1234, 8'h96, 2, 0, -1);
    do_read(16'h5678, 8'hC3, 10, 0, -1);
    do_read(16'h0F0F, 8'h81, LAT - 1, 0, -1);
    do_read(16'h2468, 8'h7E, 1, 6, -1);
    do_write(16'hBEEF, 8'h5A, 7, 4);

    // Traffic for another target must leave this one untouched.
    target_select = 1'b0;
    send_bits(32'h0000_4321, AW, MODE_ADDR, RW_WRITE, -1, 0);
    send_bits(32'h0000_00FF, DW, MODE_DATA, RW_WRITE, -1, 0);
    step();
    check("unsel_addr_pulses", n_addr_pulse, exp_addr);
    check("unsel_addr_hold", tgt_addr, 16'hBEEF);

    // Mode flips to data after 5 address bits.
    target_select = 1'b1;
    send_bits(32'h0000_001F, 5, MODE_ADDR, RW_WRITE, -1, 0);
    send_bits(32'h0000_0001, 1, MODE_DATA, RW_WRITE, -1, 0);
    target_select = 1'b0;
    repeat (2) step();
    check("abort_addr_pulses", n_addr_pulse, exp_addr);
    do_write(16'h0F1E, 8'hD2, -1, -1);

    do_read(16'hCAFE, 8'hA5, 1, 0, 3);
    do_write(16'h7001, 8'h18, -1, -1);

    for (int t = 0; t < 24; t++) begin
      ra  = AW'($urandom);
      rdv = DW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ga = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, AW - 1)) : -1;
        gd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DW - 1)) : -1;
        do_write(ra, rdv, ga, gd);
      end else begin
        dly = int'($urandom_range(0, 9));
        rdy = int'($urandom_range(0, dly + 3));
        do_read(ra, rdv, dly, rdy, -1);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    check("tot_addr_pulses", n_addr_pulse, exp_addr);
    check("tot_wdata_pulses", n_wdata_pulse, exp_wdata);
    check("tot_ack_pulses", n_ack_pulse, exp_ack);
    check("tot_drive_cycles", n_ovld, exp_ovld);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
